// File: rtl/axi_read_slave_if.sv
// AXI4 read-channel bundle (AR and R) shared by the read responder and its master.
interface axi_read_slave_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;

    modport slave (
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_read_slave.sv
// AXI4 read responder: one AR at a time, FIXED/INCR/WRAP beat addressing,
// beats fetched from a same-cycle backend port and returned on R with rlast.
module axi_read_slave #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          resetn,
    axi_read_slave_if.slave s_axi,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    input  logic [DW-1:0] rd_data_in,
    input  logic          rd_valid_in
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic [2:0]    size_q;
    logic [1:0]    burst_q;
    logic          err_q;
    logic [8:0]    cnt_q;
    logic          arready_q;
    logic          rvalid_q;
    logic          rlast_q;
    logic [1:0]    rresp_q;
    logic [DW-1:0] rdata_q;

    logic          ar_err;
    logic          slot_free;
    logic          beats_left;
    logic          load;
    logic [AW-1:0] beat_bytes;
    logic [AW-1:0] aligned;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] addr_d;

    assign slot_free  = !rvalid_q || s_axi.s_axi_rready;
    assign beats_left = cnt_q <= {1'b0, len_q};
    assign rd_en      = (state_q == BURST) && !err_q && beats_left && slot_free;
    // Error bursts still produce one beat per free slot, without the backend.
    assign load       = (state_q == BURST) && beats_left && slot_free && (err_q || rd_valid_in);

    assign ar_err = (s_axi.s_axi_arburst == 2'b11) ||
                    (s_axi.s_axi_arsize > MAX_SIZE) ||
                    ((s_axi.s_axi_arburst == 2'b10) &&
                     !(s_axi.s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        addr_d     = addr_q;
        beat_bytes = AW'(1) << size_q;
        aligned    = addr_q & ~(beat_bytes - AW'(1));
        wrap_mask  = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
        case (burst_q)
            2'b00:   addr_d = addr_q;
            2'b10:   addr_d = (addr_q & ~wrap_mask) | ((aligned + beat_bytes) & wrap_mask);
            default: addr_d = aligned + beat_bytes;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            // NOTE: rdata is a single visible output register, so it is reset like the rest.
            rdata_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so later lines see old values.
            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi.s_axi_arvalid && arready_q) begin
                        addr_q    <= s_axi.s_axi_araddr;
                        len_q     <= s_axi.s_axi_arlen;
                        size_q    <= s_axi.s_axi_arsize;
                        burst_q   <= s_axi.s_axi_arburst;
                        err_q     <= ar_err;
                        cnt_q     <= '0;
                        arready_q <= 1'b0;
                        state_q   <= BURST;
                    end
                end
                BURST: begin
                    if (load) begin
                        rdata_q  <= err_q ? '0 : rd_data_in;
                        rresp_q  <= err_q ? 2'b10 : 2'b00;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (cnt_q == {1'b0, len_q});
                        cnt_q    <= cnt_q + 9'd1;
                        addr_q   <= addr_d;
                    end else if (rvalid_q && s_axi.s_axi_rready) begin
                        rvalid_q <= 1'b0;
                    end
                    if (rvalid_q && s_axi.s_axi_rready && rlast_q) begin
                        state_q   <= IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_addr             = addr_q;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rlast   = rlast_q;
    assign s_axi.s_axi_rresp   = rresp_q;
    assign s_axi.s_axi_rdata   = rdata_q;
endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: burst types, stalls, error bursts, reset mid-burst.
module tb_axi_read_slave;
    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data_in;
    logic          rd_valid_in;

    always #5 clk = ~clk;

    axi_read_slave_if #(.AW(AW), .DW(DW)) bus ();

    axi_read_slave #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_axi      (bus.slave),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data_in (rd_data_in),
        .rd_valid_in(rd_valid_in)
    );

    function automatic logic [63:0] data_of(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    assign rd_data_in = data_of(rd_addr);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] got_addr[$];
    logic [63:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];
    logic [31:0] exp_addr[$];
    int          first_cyc;
    int          last_cyc;
    bit          saw_rd_en;
    bit          saw_arready;

    task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input bit toggle_v, input int stall_beat,
                            input bit hold_ar, input int abort_after);
        bit          done = 1'b0;
        bit          stalled;
        int          stall_cnt = 0;
        logic [63:0] held = '0;
        got_addr.delete(); got_data.delete(); got_resp.delete(); got_last.delete();
        first_cyc = -1; last_cyc = -1; saw_rd_en = 1'b0; saw_arready = 1'b0;

        check("arready_before_ar", bus.s_axi_arready, 1);
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = len;
        bus.s_axi_arsize  = size;
        bus.s_axi_arburst = burst;
        bus.s_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        if (!hold_ar) bus.s_axi_arvalid = 1'b0;
        check("arready_after_hs", bus.s_axi_arready, 0);
        check("rd_addr_start", rd_addr, addr);

        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            rd_valid_in = toggle_v ? ((cyc % 2) == 0) : 1'b1;
            stalled = bus.s_axi_rvalid && (got_data.size() == stall_beat) && (stall_cnt < 3);
            bus.s_axi_rready = !stalled;
            #1;
            if (stalled) begin
                if (stall_cnt == 0) held = bus.s_axi_rdata;
                else check("stall_rdata_stable", bus.s_axi_rdata, held);
                check("stall_rlast", bus.s_axi_rlast, 0);
                check("stall_rd_en", rd_en, 0);
                check("stall_rd_addr", rd_addr, addr);
                stall_cnt++;
            end
            if (rd_en) saw_rd_en = 1'b1;
            if (bus.s_axi_arready) saw_arready = 1'b1;
            if (rd_en && rd_valid_in) got_addr.push_back(rd_addr);
            if (bus.s_axi_rvalid && bus.s_axi_rready) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got_data.push_back(bus.s_axi_rdata);
                got_resp.push_back(bus.s_axi_rresp);
                got_last.push_back(bus.s_axi_rlast);
                if (bus.s_axi_rlast) begin
                    done = 1'b1;
                    bus.s_axi_arvalid = 1'b0;
                end
            end
            @(posedge clk); #1;
            if (abort_after >= 0 && got_data.size() == abort_after) break;
        end
        if (abort_after < 0) begin
            if (!done) check("burst_timeout", 0, 1);
            else check("arready_after_last", bus.s_axi_arready, 1);
        end
        check("arready_low_in_burst", saw_arready, 0);
        bus.s_axi_rready = 1'b1;
        rd_valid_in      = 1'b1;
    endtask

    task automatic check_beats(input int n, input bit err);
        check("beat_count", got_data.size(), n);
        check("fetch_count", got_addr.size(), err ? 0 : n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            if (err) begin
                check("err_rdata", got_data[i], 0);
                check("err_rresp", got_resp[i], 2'b10);
            end else begin
                if (i < got_addr.size()) check("beat_addr", got_addr[i], exp_addr[i]);
                check("beat_rdata", got_data[i], data_of(exp_addr[i]));
                check("beat_rresp", got_resp[i], 2'b00);
            end
            check("beat_rlast", got_last[i], i == n - 1);
        end
    endtask

    initial begin
        resetn = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
        bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b1;
        rd_valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", bus.s_axi_arready, 0);
        check("rst_rvalid", bus.s_axi_rvalid, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rdata", bus.s_axi_rdata, 0);
        @(negedge clk); resetn = 1'b1; #1;
        check("arready_before_edge", bus.s_axi_arready, 0);
        @(posedge clk); #1;
        check("arready_first_edge", bus.s_axi_arready, 1);

        // INCR aligned, full throughput
        exp_addr = '{32'h100, 32'h108, 32'h110, 32'h118};
        do_burst(32'h100, 8'd3, 3'd3, 2'b01, 1'b0, -1, 1'b0, -1);
        check_beats(4, 1'b0);
        check("incr_first_rvalid_cyc", first_cyc, 1);
        check("incr_last_cyc", last_cyc, 4);

        // WRAP around a 32-byte window
        exp_addr = '{32'h38, 32'h20, 32'h28, 32'h30};
        do_burst(32'h38, 8'd3, 3'd3, 2'b10, 1'b0, -1, 1'b0, -1);
        check_beats(4, 1'b0);

        // FIXED with a 3-cycle stall on beat 2
        exp_addr = '{32'h44, 32'h44, 32'h44};
        do_burst(32'h44, 8'd2, 3'd2, 2'b00, 1'b0, 1, 1'b0, -1);
        check_beats(3, 1'b0);

        // reserved burst type -> SLVERR, backend untouched
        do_burst(32'h200, 8'd1, 3'd3, 2'b11, 1'b0, -1, 1'b0, -1);
        check_beats(2, 1'b1);
        check("err_burst_no_rd_en", saw_rd_en, 0);

        // WRAP with illegal length
        do_burst(32'h300, 8'd2, 3'd2, 2'b10, 1'b0, -1, 1'b0, -1);
        check_beats(3, 1'b1);
        check("wrap_len_no_rd_en", saw_rd_en, 0);

        // oversize beat
        do_burst(32'h340, 8'd0, 3'd4, 2'b01, 1'b0, -1, 1'b0, -1);
        check_beats(1, 1'b1);

        // unaligned INCR start: second beat aligns up
        exp_addr = '{32'h103, 32'h104};
        do_burst(32'h103, 8'd1, 3'd2, 2'b01, 1'b0, -1, 1'b0, -1);
        check_beats(2, 1'b0);

        // INCR len=7, backend valid every other cycle, arvalid held through the burst
        exp_addr = '{32'h400, 32'h408, 32'h410, 32'h418, 32'h420, 32'h428, 32'h430, 32'h438};
        do_burst(32'h400, 8'd7, 3'd3, 2'b01, 1'b1, -1, 1'b1, -1);
        check_beats(8, 1'b0);

        // reset mid-burst after two beats
        do_burst(32'h500, 8'd7, 3'd3, 2'b01, 1'b0, -1, 1'b0, 2);
        check("abort_beats_seen", got_data.size(), 2);
        #2 resetn = 1'b0;
        #1;
        check("midrst_rvalid", bus.s_axi_rvalid, 0);
        check("midrst_arready", bus.s_axi_arready, 0);
        check("midrst_rd_en", rd_en, 0);
        check("midrst_rd_addr", rd_addr, 0);
        check("midrst_rdata", bus.s_axi_rdata, 0);
        check("midrst_rlast", bus.s_axi_rlast, 0);
        check("midrst_rresp", bus.s_axi_rresp, 0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_arready", bus.s_axi_arready, 1);
        check("post_rst_no_replay", bus.s_axi_rvalid, 0);

        exp_addr = '{32'h600};
        do_burst(32'h600, 8'd0, 3'd3, 2'b01, 1'b0, -1, 1'b0, -1);
        check_beats(1, 1'b0);
        @(posedge clk); #1;
        check("single_no_extra_beat", bus.s_axi_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
